// File: rtl/adc_sample_ctrl.sv
// adc_sample_ctrl: track/hold sequencer for the 8-bit flash ADC feeding a one-entry
// valid/ready result register. Define ADC_SAMPLE_CTRL_AVG_EN to average 2^AVG_LOG2 captures.
module adc_sample_ctrl #(
    parameter int DIV        = 20,
    parameter int TRACK_CYC  = 4,
    parameter int SETTLE_CYC = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] code,
    input  logic       clr_ovr,
    output logic       sh_track,
    output logic       busy,
    output logic [7:0] sample_data,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       overrun
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TRACK_LAST  = CW'(TRACK_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(TRACK_CYC + SETTLE_CYC - 1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(32'd1);

    // Reject parameter sets that cannot fit a full conversion in one period.
    if ((TRACK_CYC < 1) || (SETTLE_CYC < 1) || (DIV < TRACK_CYC + SETTLE_CYC + 2)
        || (AVG_LOG2 < 0) || (AVG_LOG2 > 4)) begin : g_param_check
        $error("adc_sample_ctrl: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRACK   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        WAIT    = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          sh_track_r;
    logic          busy_r;
    logic [7:0]    data_r;
    logic          valid_r;
    logic          overrun_r;
    logic          result_evt_s;
    logic [7:0]    result_s;
    logic          load_s;
    logic          drop_s;
    logic          consume_s;

    // Next-state and period counter; the counter restarts at every TRACK entry.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_ONE;
        case (state_r)
            IDLE: begin
                cnt_nxt_s = '0;
                if (en) begin
                    state_nxt_s = TRACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TRACK: begin
                if (cnt_r == TRACK_LAST) begin
                    state_nxt_s = SETTLE;
                end else begin
                    state_nxt_s = TRACK;
                end
            end
            SETTLE: begin
                if (cnt_r == SETTLE_LAST) begin
                    state_nxt_s = CAPTURE;
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            CAPTURE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (cnt_r == PERIOD_LAST) begin
                    cnt_nxt_s = '0;
                    if (en) begin
                        state_nxt_s = TRACK;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Sequencer state plus outputs decoded from the next state so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            sh_track_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            sh_track_r <= (state_nxt_s != SETTLE) && (state_nxt_s != CAPTURE);
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

`ifdef ADC_SAMPLE_CTRL_AVG_EN
    localparam int AW = 8 + AVG_LOG2;
    localparam int GW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [GW-1:0] GRP_LAST = GW'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [GW-1:0] GRP_ONE  = GW'(32'd1);

    logic [AW-1:0] acc_r;
    logic [AW-1:0] sum_s;
    logic [GW-1:0] grp_r;
    logic          capture_s;
    logic          grp_done_s;

    // A result fires on the capture that completes a group; the top byte is the mean.
    always_comb begin
        capture_s    = (state_r == CAPTURE);
        sum_s        = acc_r + AW'(code);
        grp_done_s   = (grp_r == GRP_LAST);
        result_evt_s = capture_s && grp_done_s;
        result_s     = sum_s[AW-1 -: 8];
    end

    // Accumulator; a partial group is discarded whenever the sequencer drops to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
            grp_r <= '0;
        end else if (state_nxt_s == IDLE) begin
            acc_r <= '0;
            grp_r <= '0;
        end else if (capture_s) begin
            if (grp_done_s) begin
                acc_r <= '0;
                grp_r <= '0;
            end else begin
                acc_r <= sum_s;
                grp_r <= grp_r + GRP_ONE;
            end
        end else begin
            acc_r <= acc_r;
            grp_r <= grp_r;
        end
    end
`else
    // Without averaging every capture is delivered as-is.
    always_comb begin
        result_evt_s = (state_r == CAPTURE);
        result_s     = code;
    end
`endif

    // Handshake decode: a full register with no taker drops the new result.
    always_comb begin
        load_s    = result_evt_s && (!valid_r || sample_ready);
        drop_s    = result_evt_s && valid_r && !sample_ready;
        consume_s = !result_evt_s && valid_r && sample_ready;
    end

    // One-entry result register with sticky overrun; a new drop beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r    <= 8'h00;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (load_s) begin
                data_r  <= result_s;
                valid_r <= 1'b1;
            end else if (consume_s) begin
                valid_r <= 1'b0;
            end
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clr_ovr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign sh_track     = sh_track_r;
    assign busy         = busy_r;
    assign sample_data  = data_r;
    assign sample_valid = valid_r;
    assign overrun      = overrun_r;

endmodule
